// File: rtl/pool_pkg.sv
// Shared definitions for the pooling controller: pool pipeline latency
// and the controller state encoding.
package pool_pkg;

    // Cycles from the last accepted element to a valid pool maximum.
    localparam int POOL_LATENCY = 4;
    localparam int DRAIN_W      = $clog2(POOL_LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/pool.sv
// Streaming signed max-pool core with a fixed POOL_LATENCY pipeline.
// Ports: clk; restart/up_valid/up_data element input; dn_data running max.
module pool
    import pool_pkg::*;
#(
    parameter int NUM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 restart,
    input  logic                 up_valid,
    input  logic [NUM_WIDTH-1:0] up_data,
    output logic [NUM_WIDTH-1:0] dn_data
);

    logic signed [NUM_WIDTH-1:0] acc;
    logic        [NUM_WIDTH-1:0] pipe [POOL_LATENCY-1];

    // No reset on purpose: restart on a window's first element overwrites
    // whatever the accumulator held. Strict '>' keeps the earlier tie.
    always_ff @(posedge clk) begin
        if (up_valid) begin
            if (restart || ($signed(up_data) > acc)) begin
                acc <= up_data;
            end
        end
        pipe[0] <= acc;
        for (int i = 1; i < POOL_LATENCY - 1; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign dn_data = pipe[POOL_LATENCY-2];

endmodule

// File: rtl/pool_ctrl.sv
// Job controller feeding windows of signed elements into one pool core.
// Ports: clk, rst; start/cfg_size/cfg_count/busy/done job control;
// up_* element stream in; dn_* window maximum out (valid/ready).
// Optional: define POOL_CTRL_RELU_EN to clamp negative results to 0.
module pool_ctrl
    import pool_pkg::*;
#(
    parameter int NUM_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] cfg_size,
    input  logic [CNT_WIDTH-1:0] cfg_count,
    output logic                 busy,
    output logic                 done,
    input  logic [NUM_WIDTH-1:0] up_data,
    input  logic                 up_valid,
    output logic                 up_ready,
    output logic [NUM_WIDTH-1:0] dn_data,
    output logic                 dn_valid,
    input  logic                 dn_ready
);

    state_t               state;
    state_t               next;
    logic [CNT_WIDTH-1:0] size_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] elem_cnt;
    logic [CNT_WIDTH-1:0] win_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 zero_done;
    logic [NUM_WIDTH-1:0] pool_dn;

    logic accept;
    logic restart;
    logic last_elem;
    logic last_win;
    logic drain_end;
    logic cfg_ok;
    logic launch;

    assign up_ready  = (state == FEED);
    assign dn_valid  = (state == OUT);
    assign busy      = (state != IDLE);

    assign accept    = up_valid & up_ready;
    assign restart   = accept && (elem_cnt == '0);
    assign last_elem = (elem_cnt == size_q - 1'b1);
    assign last_win  = (win_cnt == count_q - 1'b1);
    assign drain_end = (drain_cnt == DRAIN_W'(POOL_LATENCY - 1));
    assign cfg_ok    = (cfg_size != '0) && (cfg_count != '0);
    assign launch    = (state == IDLE) && start && cfg_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        done = zero_done;
        unique case (state)
            IDLE: begin
                if (launch) next = FEED;
            end
            FEED: begin
                if (accept && last_elem) next = DRAIN;
            end
            DRAIN: begin
                if (drain_end) next = OUT;
            end
            OUT: begin
                if (dn_ready) begin
                    if (last_win) begin
                        next = IDLE;
                        done = 1'b1;
                    end else begin
                        next = FEED;
                    end
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q    <= '0;
            count_q   <= '0;
            elem_cnt  <= '0;
            win_cnt   <= '0;
            drain_cnt <= '0;
            zero_done <= 1'b0;
            dn_data   <= '0;
        end else begin
            // A degenerate job never leaves IDLE; it only reports done.
            zero_done <= (state == IDLE) && start && !cfg_ok;
            if (launch) begin
                size_q   <= cfg_size;
                count_q  <= cfg_count;
                elem_cnt <= '0;
                win_cnt  <= '0;
            end
            if (accept) begin
                elem_cnt <= last_elem ? '0 : elem_cnt + 1'b1;
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_end ? '0 : drain_cnt + 1'b1;
                if (drain_end) begin
`ifdef POOL_CTRL_RELU_EN
                    dn_data <= pool_dn[NUM_WIDTH-1] ? '0 : pool_dn;
`else
                    dn_data <= pool_dn;
`endif
                end
            end
            if ((state == OUT) && dn_ready) begin
                win_cnt <= last_win ? '0 : win_cnt + 1'b1;
            end
        end
    end

    pool #(
        .NUM_WIDTH (NUM_WIDTH)
    ) u_pool (
        .clk      (clk),
        .restart  (restart),
        .up_valid (accept),
        .up_data  (up_data),
        .dn_data  (pool_dn)
    );

endmodule

// File: tb/tb_pool_ctrl.sv
// Self-checking bench for pool_ctrl: table-driven jobs plus directed
// sequences for backpressure, degenerate starts and mid-job reset.
module tb_pool_ctrl;

    typedef struct {
        int size;
        int count;
        int data [8];
        int exp  [2];
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         cfg_size;
    logic [7:0]         cfg_count;
    logic               busy;
    logic               done;
    logic signed [15:0] up_data;
    logic               up_valid;
    logic               up_ready;
    logic signed [15:0] dn_data;
    logic               dn_valid;
    logic               dn_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    vec_t vecs [6];

    pool_ctrl #(
        .NUM_WIDTH (16),
        .CNT_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_size  (cfg_size),
        .cfg_count (cfg_count),
        .busy      (busy),
        .done      (done),
        .up_data   (up_data),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .dn_data   (dn_data),
        .dn_valid  (dn_valid),
        .dn_ready  (dn_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic int relu(input int x);
`ifdef POOL_CTRL_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic launch(input int size, input int count);
        @(negedge clk);
        start     = 1'b1;
        cfg_size  = 8'(size);
        cfg_count = 8'(count);
        up_valid  = 1'b0;
        dn_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    // Streams one job with no bubbles and dn_ready held high.
    task automatic run_job(input vec_t v, input int id);
        int idx      = 0;
        int res      = 0;
        int last_acc = 0;
        int guard    = 0;
        int total;
        total = v.size * v.count;
        launch(v.size, v.count);
        check($sformatf("job%0d busy", id), int'(busy), 1);
        while (res < v.count && guard < 300) begin
            up_valid = (idx < total);
            up_data  = (idx < 8) ? 16'(v.data[idx]) : 16'sd0;
            if (up_valid && up_ready) begin
                idx++;
                last_acc = cyc;
            end
            #1;
            if (dn_valid) begin
                check($sformatf("job%0d w%0d latency", id, res),
                      cyc - last_acc, 5);
                check($sformatf("job%0d w%0d data", id, res),
                      int'(dn_data), relu(v.exp[res]));
                check($sformatf("job%0d w%0d done", id, res),
                      int'(done), (res == v.count - 1) ? 1 : 0);
                res++;
            end
            @(negedge clk);
            guard++;
        end
        up_valid = 1'b0;
        if (guard >= 300) check($sformatf("job%0d timeout", id), 0, 1);
        #1;
        check($sformatf("job%0d idle busy", id), int'(busy), 0);
        check($sformatf("job%0d idle done", id), int'(done), 0);
    endtask

    initial begin
        int accepts;
        int guard;

        vecs[0] = '{4, 1, '{3, -2, 7, 5, 0, 0, 0, 0}, '{7, 0}};
        vecs[1] = '{3, 2, '{-5, -1, -9, -8, -3, -4, 0, 0}, '{-1, -3}};
        vecs[2] = '{1, 2, '{-7, 9, 0, 0, 0, 0, 0, 0}, '{-7, 9}};
        vecs[3] = '{3, 1, '{5, 5, 2, 0, 0, 0, 0, 0}, '{5, 0}};
        vecs[4] = '{2, 1, '{32767, -32768, 0, 0, 0, 0, 0, 0}, '{32767, 0}};
        vecs[5] = '{2, 1, '{-4, -7, 0, 0, 0, 0, 0, 0}, '{-4, 0}};

        rst       = 1'b1;
        start     = 1'b0;
        cfg_size  = '0;
        cfg_count = '0;
        up_data   = '0;
        up_valid  = 1'b0;
        dn_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset up_ready", int'(up_ready), 0);
        check("reset dn_valid", int'(dn_valid), 0);
        check("reset dn_data", int'(dn_data), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i], i);
        end

        // Bubbles between elements, a start while busy, long backpressure.
        accepts = 0;
        launch(2, 1);
        up_valid = 1'b1;
        up_data  = 16'sd10;
        if (up_ready) accepts++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            up_valid  = 1'b0;
            start     = (i == 1);
            cfg_size  = 8'd5;
            cfg_count = 8'd3;
        end
        @(negedge clk);
        start    = 1'b0;
        up_valid = 1'b1;
        up_data  = 16'sd20;
        if (up_ready) accepts++;
        dn_ready = 1'b0;
        @(negedge clk);
        up_data = 16'sd99;
        guard   = 0;
        while (!dn_valid && guard < 20) begin
            if (up_ready) accepts++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("bp wait dn_valid", 0, 1);
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("bp hold data %0d", i), int'(dn_data), 20);
            check($sformatf("bp hold valid %0d", i), int'(dn_valid), 1);
            check($sformatf("bp hold done %0d", i), int'(done), 0);
            if (up_ready) accepts++;
            @(negedge clk);
        end
        check("bp accepts", accepts, 2);
        up_valid = 1'b0;
        dn_ready = 1'b1;
        #1;
        check("bp done", int'(done), 1);
        @(negedge clk);
        #1;
        check("bp idle", int'(busy), 0);

        // Degenerate starts: zero size, then zero count.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start     = 1'b1;
            cfg_size  = (k == 0) ? 8'd0 : 8'd2;
            cfg_count = (k == 0) ? 8'd3 : 8'd0;
            #1;
            check($sformatf("zero%0d done early", k), int'(done), 0);
            @(negedge clk);
            start = 1'b0;
            #1;
            check($sformatf("zero%0d done", k), int'(done), 1);
            check($sformatf("zero%0d busy", k), int'(busy), 0);
            @(negedge clk);
            #1;
            check($sformatf("zero%0d done once", k), int'(done), 0);
            check($sformatf("zero%0d busy after", k), int'(busy), 0);
        end

        // Reset in FEED after one element, then a fresh job.
        launch(2, 1);
        up_valid = 1'b1;
        up_data  = 16'sd100;
        @(negedge clk);
        up_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst busy", int'(busy), 0);
        check("rst up_ready", int'(up_ready), 0);
        check("rst dn_valid", int'(dn_valid), 0);
        check("rst dn_data", int'(dn_data), 0);
        check("rst done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst no done %0d", i), int'(done), 0);
        end
        run_job('{2, 1, '{1, 2, 0, 0, 0, 0, 0, 0}, '{2, 0}}, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_ctrl.md
POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 Parameter NUM_WIDTH, default 16: signed data width, passed to the pool instance.
REQ-002 Parameter CNT_WIDTH, default 8: width of the window-size and window-count fields.
REQ-003 Port clk, input, 1: single clock; all logic is on posedge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port start, input, 1: launches a job; sampled only in IDLE.
REQ-006 Port cfg_size, input, CNT_WIDTH: elements per pooling window; latched on start.
REQ-007 Port cfg_count, input, CNT_WIDTH: windows per job; latched on start.
REQ-008 Port busy, output, 1: high whenever state is not IDLE.
REQ-009 Port done, output, 1: one-cycle pulse at job end.
REQ-010 Port up_data, input, NUM_WIDTH: signed element stream.
REQ-011 Port up_valid, input, 1: upstream element valid.
REQ-012 Port up_ready, output, 1: element accepted when up_valid and up_ready are both high.
REQ-013 Port dn_data, output, NUM_WIDTH: window maximum.
REQ-014 Port dn_valid, output, 1: result valid; held until accepted.
REQ-015 Port dn_ready, input, 1: result accepted when dn_valid and dn_ready are both high.

Function
REQ-016 The state machine SHALL have states IDLE, FEED, DRAIN and OUT.
REQ-017 IDLE->FEED SHALL occur on start when cfg_size!=0 and cfg_count!=0; a start with either field zero SHALL pulse done the next cycle and stay in IDLE.
REQ-018 up_ready SHALL be 1 only in FEED.
REQ-019 An element counter SHALL count accepted elements; FEED->DRAIN SHALL occur on acceptance of the cfg_size-th element.
REQ-020 Pool restart SHALL be asserted in the same cycle as acceptance of the first element of each window, and at no other time.
REQ-021 Pool up_valid SHALL equal up_valid & up_ready; pool up_data SHALL equal up_data.
REQ-022 DRAIN SHALL last exactly POOL_LATENCY (4) cycles; on exit, pool dn_data SHALL be captured into dn_data, and the state SHALL go to OUT.
REQ-023 In OUT, dn_valid SHALL be 1 and dn_data SHALL be stable until dn_ready.
REQ-024 On the OUT handshake: if windows remain, the state SHALL go to FEED; otherwise it SHALL go to IDLE with done pulsed in that cycle.
REQ-025 A bubble (up_valid low) in FEED SHALL stall the counter without affecting the result.
REQ-026 cfg_size=1: each window result SHALL equal its single element.
REQ-027 Comparison SHALL be signed; ties SHALL keep the earlier value.
REQ-028 start while busy SHALL be ignored.
REQ-029 Counters SHALL be CNT_WIDTH wide and SHALL never wrap within a job.

Reset
REQ-030 rst SHALL force IDLE immediately and clear busy, done, up_ready, dn_valid, dn_data and all counters to 0.
REQ-031 Reset mid-job SHALL abandon the job with no done pulse; the unreset pool state SHALL be neutralised by the next window's restart.

Configuration
REQ-032 With POOL_CTRL_RELU_EN defined, a captured negative result SHALL be replaced by 0; without it, the result SHALL pass unchanged.

Structure
REQ-033 Package pool_pkg SHALL hold POOL_LATENCY=4 and the state encoding.
REQ-034 The sole sub-module SHALL be one instance of pool, with NUM_WIDTH passed through.

Verification
REQ-035 cfg_size=4, cfg_count=1, input 3,-2,7,5 -> dn_data=7; first dn_valid 5 cycles after the last accept; done pulses on the handshake.
REQ-036 cfg_size=3, cfg_count=2, input -5,-1,-9 then -8,-3,-4 -> results -1 then -3, confirming restart isolates windows.
REQ-037 cfg_size=2, up_valid bubbles of 3 cycles between elements 10 and 20, dn_ready held low for 6 cycles -> dn_data=20 held stable, no extra accepts.
REQ-038 cfg_size=0 start -> done the next cycle, busy never high.
REQ-039 rst asserted mid-FEED, then a new job of 1,2 -> result 2, no stale data, no done from the aborted job.
REQ-040 POOL_CTRL_RELU_EN defined, input -4,-7 -> dn_data=0; macro undefined -> dn_data=-4.
